// File: rtl/unit_a_depth_accumulator_if.sv
// rtl/unit_a_depth_accumulator_if.sv - partial-sum input and biased-result output bundle
interface unit_a_depth_accumulator_if #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDRESS_SIZE_BIAS = 7
);
    logic [DATA_WIDTH-1:0]        acc_data_in;
    logic                         acc_valid_in;
    logic [DATA_WIDTH-1:0]        acc_data_out;
    logic                         acc_valid_out;
    logic [ADDRESS_SIZE_BIAS-1:0] filter_index;
    logic                         layer_done;

    modport master (
        output acc_data_in,
        output acc_valid_in,
        input  acc_data_out,
        input  acc_valid_out,
        input  filter_index,
        input  layer_done
    );

    modport slave (
        input  acc_data_in,
        input  acc_valid_in,
        output acc_data_out,
        output acc_valid_out,
        output filter_index,
        output layer_done
    );
endinterface

// File: rtl/unit_a_depth_accumulator.sv
// rtl/unit_a_depth_accumulator.sv - depth accumulator with per-filter bias and optional ReLU
module unit_a_depth_accumulator #(
    parameter int DATA_WIDTH        = 32,
    parameter int IFM_DEPTH         = 16,
    parameter int NUMBER_OF_FILTERS = 120,
    parameter int RELU_ENABLE       = 1,
    parameter int ADDRESS_SIZE_BIAS = $clog2(NUMBER_OF_FILTERS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        riscv_data,
    input  logic                         bias_write_enable,
    input  logic [ADDRESS_SIZE_BIAS-1:0] bias_address,
    input  logic                         clear,
    unit_a_depth_accumulator_if.slave    acc_if
);

    localparam int DEPTH_W = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0]           LAST_DEPTH  = DEPTH_W'(IFM_DEPTH - 1);
    localparam logic [ADDRESS_SIZE_BIAS-1:0] LAST_FILTER = ADDRESS_SIZE_BIAS'(NUMBER_OF_FILTERS - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                       state_q, state_d;
    logic [DEPTH_W-1:0]           depth_cnt_q, depth_cnt_d;
    logic [ADDRESS_SIZE_BIAS-1:0] filter_cnt_q, filter_cnt_d;
    logic [DATA_WIDTH-1:0]        accum_q, accum_d;
    logic [DATA_WIDTH-1:0]        acc_data_out_q, acc_data_out_d;
    logic                         acc_valid_out_q, acc_valid_out_d;
    logic                         layer_done_q, layer_done_d;

    logic [DATA_WIDTH-1:0]        bias_q [NUMBER_OF_FILTERS];

    logic [ADDRESS_SIZE_BIAS-1:0] filter_next;
    logic [ADDRESS_SIZE_BIAS-1:0] cur_filter;
    logic [DEPTH_W-1:0]           depth_now;
    logic [DATA_WIDTH-1:0]        accum_base;
    logic [DATA_WIDTH-1:0]        partial;
    logic [DATA_WIDTH-1:0]        sum;
    logic                         is_last;

    // Bias storage survives reset and clear; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (bias_write_enable && (32'(bias_address) < NUMBER_OF_FILTERS)) begin
            bias_q[bias_address] <= riscv_data;
        end
    end

    // The filter counter steps during the output pulse, so a back-to-back
    // completion in that cycle must already see the next filter's bias.
    always_comb begin
        filter_next = (filter_cnt_q == LAST_FILTER) ? '0 : filter_cnt_q + 1'b1;
        cur_filter  = acc_valid_out_q ? filter_next : filter_cnt_q;
        depth_now   = (state_q == ACCUM) ? depth_cnt_q : '0;
        accum_base  = (state_q == ACCUM) ? accum_q : '0;
        partial     = accum_base + acc_if.acc_data_in;
        sum         = partial + bias_q[cur_filter];
        is_last     = (depth_now == LAST_DEPTH);
    end

    always_comb begin
        state_d         = state_q;
        depth_cnt_d     = depth_cnt_q;
        filter_cnt_d    = cur_filter;
        accum_d         = accum_q;
        acc_data_out_d  = acc_data_out_q;
        acc_valid_out_d = 1'b0;
        layer_done_d    = 1'b0;

        if (clear) begin
            state_d      = IDLE;
            depth_cnt_d  = '0;
            filter_cnt_d = '0;
            accum_d      = '0;
        end else if (acc_if.acc_valid_in) begin
            if (is_last) begin
                state_d         = IDLE;
                depth_cnt_d     = '0;
                accum_d         = '0;
                acc_data_out_d  = ((RELU_ENABLE != 0) && sum[DATA_WIDTH-1]) ? '0 : sum;
                acc_valid_out_d = 1'b1;
                layer_done_d    = (cur_filter == LAST_FILTER);
            end else begin
                state_d     = ACCUM;
                depth_cnt_d = depth_now + 1'b1;
                accum_d     = partial;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            depth_cnt_q     <= '0;
            filter_cnt_q    <= '0;
            accum_q         <= '0;
            acc_data_out_q  <= '0;
            acc_valid_out_q <= 1'b0;
            layer_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            depth_cnt_q     <= depth_cnt_d;
            filter_cnt_q    <= filter_cnt_d;
            accum_q         <= accum_d;
            acc_data_out_q  <= acc_data_out_d;
            acc_valid_out_q <= acc_valid_out_d;
            layer_done_q    <= layer_done_d;
        end
    end

    assign acc_if.acc_data_out  = acc_data_out_q;
    assign acc_if.acc_valid_out = acc_valid_out_q;
    assign acc_if.filter_index  = filter_cnt_q;
    assign acc_if.layer_done    = layer_done_q;

endmodule

// File: tb/tb_unit_a_depth_accumulator.sv
// tb/tb_unit_a_depth_accumulator.sv - scoreboard bench for unit_a_depth_accumulator
module tb_unit_a_depth_accumulator;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    logic [31:0] a_bd, b_bd;
    logic        a_we, b_we, a_clr, b_clr;
    logic [6:0]  a_addr;
    logic [1:0]  b_addr;

    unit_a_depth_accumulator_if #(.DATA_WIDTH(32), .ADDRESS_SIZE_BIAS(7)) ifa ();
    unit_a_depth_accumulator_if #(.DATA_WIDTH(32), .ADDRESS_SIZE_BIAS(2)) ifb ();

    unit_a_depth_accumulator #(
        .DATA_WIDTH(32), .IFM_DEPTH(16), .NUMBER_OF_FILTERS(120), .RELU_ENABLE(1)
    ) dut_a (
        .clk(clk), .reset(rst_n), .riscv_data(a_bd), .bias_write_enable(a_we),
        .bias_address(a_addr), .clear(a_clr), .acc_if(ifa.slave)
    );

    unit_a_depth_accumulator #(
        .DATA_WIDTH(32), .IFM_DEPTH(2), .NUMBER_OF_FILTERS(4), .RELU_ENABLE(0)
    ) dut_b (
        .clk(clk), .reset(rst_n), .riscv_data(b_bd), .bias_write_enable(b_we),
        .bias_address(b_addr), .clear(b_clr), .acc_if(ifb.slave)
    );

    typedef struct {
        logic [31:0] data;
        int          filt;
        bit          done;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int          m_cnt [2];
    logic [31:0] m_sum [2];
    int          m_f   [2];
    logic [31:0] m_bias[2][128];

    function automatic int dep(int sel);
        return (sel == 0) ? 16 : 2;
    endfunction

    function automatic int nfil(int sel);
        return (sel == 0) ? 120 : 4;
    endfunction

    function automatic bit relu(int sel);
        return (sel == 0);
    endfunction

    function automatic int rnd();
        return int'($urandom_range(0, 200000)) - 100000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(int sel, bit v, logic [31:0] d, bit we, int addr, logic [31:0] bd, bit clr);
        exp_t e;
        logic [31:0] s;
        @(negedge clk);
        ifa.acc_valid_in = 1'b0; ifa.acc_data_in = '0; a_we = 1'b0; a_clr = 1'b0; a_addr = '0; a_bd = '0;
        ifb.acc_valid_in = 1'b0; ifb.acc_data_in = '0; b_we = 1'b0; b_clr = 1'b0; b_addr = '0; b_bd = '0;
        if (sel == 0) begin
            ifa.acc_valid_in = v; ifa.acc_data_in = d; a_we = we; a_addr = 7'(addr); a_bd = bd; a_clr = clr;
        end else begin
            ifb.acc_valid_in = v; ifb.acc_data_in = d; b_we = we; b_addr = 2'(addr); b_bd = bd; b_clr = clr;
        end
        if (clr) begin
            m_cnt[sel] = 0; m_sum[sel] = '0; m_f[sel] = 0;
        end else if (v) begin
            m_sum[sel] = m_sum[sel] + d;
            m_cnt[sel]++;
            if (m_cnt[sel] == dep(sel)) begin
                s      = m_sum[sel] + m_bias[sel][m_f[sel]];
                e.data = (relu(sel) && $signed(s) < 0) ? 32'd0 : s;
                e.filt = m_f[sel];
                e.done = (m_f[sel] == nfil(sel) - 1);
                e.cyc  = cyc + 1;
                if (sel == 0) q0.push_back(e); else q1.push_back(e);
                m_f[sel]   = (m_f[sel] + 1) % nfil(sel);
                m_cnt[sel] = 0;
                m_sum[sel] = '0;
            end
        end
        if (we && addr < nfil(sel)) m_bias[sel][addr] = bd;
    endtask

    task automatic feed(int sel, logic [31:0] d);
        step(sel, 1'b1, d, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 1'b0, '0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ifa.acc_valid_in = 1'b0; ifb.acc_valid_in = 1'b0;
        a_we = 1'b0; b_we = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_cnt[s] = 0; m_sum[s] = '0; m_f[s] = 0;
        end
        #1;
        chk("rst_a_data",  ifa.acc_data_out, 32'd0);
        chk("rst_a_valid", 32'(ifa.acc_valid_out), 32'd0);
        chk("rst_a_index", 32'(ifa.filter_index), 32'd0);
        chk("rst_a_done",  32'(ifa.layer_done), 32'd0);
        chk("rst_b_data",  ifb.acc_data_out, 32'd0);
        chk("rst_b_index", 32'(ifb.filter_index), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic mon(int sel);
        logic        v, dn;
        logic [31:0] d;
        int          fi, qs;
        exp_t        e;
        if (sel == 0) begin
            v = ifa.acc_valid_out; dn = ifa.layer_done; d = ifa.acc_data_out; fi = int'(ifa.filter_index); qs = q0.size();
        end else begin
            v = ifb.acc_valid_out; dn = ifb.layer_done; d = ifb.acc_data_out; fi = int'(ifb.filter_index); qs = q1.size();
        end
        if (v) begin
            tests++;
            if (qs == 0) begin
                fails++;
                $display("FAIL d%0d_unexpected_pulse: got data %h expected no pulse", sel, d);
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("d%0d_data", sel), d, e.data);
                chk($sformatf("d%0d_filter", sel), 32'(fi), 32'(e.filt));
                chk($sformatf("d%0d_done", sel), 32'(dn), 32'(e.done));
                chk($sformatf("d%0d_latency", sel), 32'(cyc), 32'(e.cyc));
            end
        end else if (dn) begin
            tests++;
            fails++;
            $display("FAIL d%0d_stray_done: got layer_done 1 expected 0 without valid", sel);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vals [16];
        cyc = 0; tests = 0; fails = 0;
        rst_n = 1'b0;
        ifa.acc_valid_in = 1'b0; ifa.acc_data_in = '0; ifb.acc_valid_in = 1'b0; ifb.acc_data_in = '0;
        a_we = 1'b0; b_we = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
        a_addr = '0; b_addr = '0; a_bd = '0; b_bd = '0;
        do_reset();

        for (int i = 0; i < 120; i++)
            step(0, 1'b0, '0, 1'b1, i, (i == 0) ? 32'd5 : (i == 3) ? -32'sd100 : 32'(int'($urandom_range(0, 2000)) - 1000), 1'b0);
        for (int i = 0; i < 4; i++)
            step(1, 1'b0, '0, 1'b1, i, (i == 0) ? 32'd0 : (i == 3) ? -32'sd100 : 32'(rnd()), 1'b0);

        repeat (16) feed(0, 32'd1);
        idle(2);
        chk("basic_data", ifa.acc_data_out, 32'd21);
        chk("basic_index", 32'(ifa.filter_index), 32'd1);

        repeat (32) feed(0, 32'(rnd()));
        repeat (15) feed(0, 32'd2);
        feed(0, 32'd10);
        idle(2);
        chk("relu_data", ifa.acc_data_out, 32'd0);
        chk("relu_index", 32'(ifa.filter_index), 32'd4);

        step(0, 1'b1, 32'd123, 1'b0, 0, '0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            vals[i] = 32'(rnd());
            feed(0, vals[i]);
            idle(1);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 16; i++) feed(0, vals[i]);
        idle(3);

        step(0, 1'b0, '0, 1'b0, 0, '0, 1'b1);
        repeat (7) feed(0, 32'(rnd()));
        step(0, 1'b0, '0, 1'b0, 0, '0, 1'b1);
        repeat (16) feed(0, 32'(rnd()));
        idle(2);
        repeat (7) feed(0, 32'(rnd()));
        do_reset();
        repeat (16) feed(0, 32'(rnd()));
        idle(2);

        repeat (10) feed(0, 32'(rnd()));
        step(0, 1'b0, '0, 1'b1, 1, 32'd777, 1'b0);
        repeat (5) feed(0, 32'(rnd()));
        step(0, 1'b1, 32'(rnd()), 1'b1, 1, 32'd999, 1'b0);
        step(0, 1'b0, '0, 1'b1, 125, 32'hDEAD_BEEF, 1'b0);
        idle(2);

        step(0, 1'b0, '0, 1'b0, 0, '0, 1'b1);
        for (int f = 0; f < 120; f++)
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                feed(0, 32'(rnd()));
            end
        idle(3);
        chk("wrap_index", 32'(ifa.filter_index), 32'd0);

        step(1, 1'b0, '0, 1'b0, 0, '0, 1'b1);
        feed(1, 32'h7FFF_FFFF);
        feed(1, 32'd1);
        idle(2);
        chk("ovf_data", ifb.acc_data_out, 32'h8000_0000);
        repeat (4) feed(1, 32'(rnd()));
        feed(1, 32'd20);
        feed(1, 32'd20);
        idle(2);
        chk("norelu_data", ifb.acc_data_out, 32'hFFFF_FFC4);
        chk("norelu_index", 32'(ifb.filter_index), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) step(1, 1'b0, '0, 1'b1, int'($urandom_range(0, 3)), 32'(rnd()), 1'b0);
            feed(1, 32'(rnd()));
        end

        idle(5);
        chk("a_queue_empty", 32'(q0.size()), 32'd0);
        chk("b_queue_empty", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unit_a_depth_accumulator.md
UNIT_A_DEPTH_ACCUMULATOR -- requirements
Module: unit_a_depth_accumulator

Interface
REQ-001 The block SHALL take parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, word width of all data paths.
- IFM_DEPTH, 16, number of per-channel partial sums per output value.
- NUMBER_OF_FILTERS, 120, number of filters (biases) per layer pass.
- RELU_ENABLE, 1, 1 clamps negative results to 0; 0 passes them through.
- ADDRESS_SIZE_BIAS, $clog2(NUMBER_OF_FILTERS), bias address width.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- riscv_data, in, DATA_WIDTH, bias write data.
- bias_write_enable, in, 1, writes riscv_data to bias_address.
- bias_address, in, ADDRESS_SIZE_BIAS, bias write address.
- clear, in, 1, synchronous restart of counters and accumulator.
- acc_data_in, in, DATA_WIDTH, signed partial sum from the convolution unit (unit_data_out).
- acc_valid_in, in, 1, acc_data_in is valid this cycle.
- acc_data_out, out, DATA_WIDTH, final biased and activated result.
- acc_valid_out, out, 1, one-cycle pulse qualifying acc_data_out.
- filter_index, out, ADDRESS_SIZE_BIAS, filter number of the current or last result.
- layer_done, out, 1, one-cycle pulse with the last filter's result.

Function
REQ-003 The block SHALL hold a NUMBER_OF_FILTERS x DATA_WIDTH bias register file.
- Writes are synchronous.
- A write with bias_address >= NUMBER_OF_FILTERS is ignored.
- Bias contents are not cleared by reset or clear.

REQ-004 The FSM SHALL have two states, IDLE and ACCUM; the reset state is IDLE.

REQ-005 In IDLE, acc_valid_in=1 SHALL load accum <= acc_data_in, set depth_cnt <= 1, and move the FSM to ACCUM.
- Special case IFM_DEPTH=1: apply REQ-007 instead and stay in IDLE.

REQ-006 In ACCUM, acc_valid_in=1 with depth_cnt < IFM_DEPTH-1 SHALL do accum <= accum + acc_data_in and depth_cnt <= depth_cnt+1.

REQ-007 A valid input with depth_cnt = IFM_DEPTH-1 SHALL compute sum = accum + acc_data_in + bias[filter_cnt] and register the output on the same edge.
- Output = RELU_ENABLE && sum<0 ? 0 : sum.
- acc_valid_out=1 for exactly the next cycle.
- The FSM returns to IDLE.
- Latency: one cycle from the last valid input to acc_valid_out.

REQ-008 Cycles with acc_valid_in=0 SHALL leave all state unchanged (gaps allowed). acc_data_out SHALL hold its last value between pulses.

REQ-009 All additions SHALL be two's complement modulo 2^DATA_WIDTH. Overflow wraps and is not flagged.

REQ-010 filter_index SHALL equal filter_cnt, the filter whose sum is in progress.
- It advances by 1 on the edge after each acc_valid_out pulse.
- After index NUMBER_OF_FILTERS-1 it wraps to 0.

REQ-011 layer_done SHALL pulse together with acc_valid_out when filter_cnt = NUMBER_OF_FILTERS-1.

REQ-012 Back-to-back operation: a valid input in the cycle right after a completing input SHALL be taken as depth 0 of the next filter (IDLE behaviour), with no bubble.

REQ-013 clear=1 SHALL force IDLE and zero depth_cnt, filter_cnt, accum, acc_valid_out and layer_done on the next edge.
- clear has priority over acc_valid_in.
- clear also has priority over bias writes to counters; bias writes still occur.

REQ-014 A bias write to the address currently in use SHALL be visible to a completion one or more cycles later. Same-cycle write-and-complete uses the old bias.

Reset
REQ-015 reset=0 SHALL asynchronously force:
- FSM to IDLE.
- depth_cnt, filter_cnt, accum, acc_data_out to 0.
- acc_valid_out and layer_done to 0.
- filter_index to 0.

REQ-016 Reset asserted mid-accumulation SHALL discard the partial sum. No output pulse SHALL follow release.

REQ-017 After reset is released, the first valid input SHALL be treated as depth 0 of filter 0.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios:
- Basic sum: IFM_DEPTH=16, bias[0]=5, sixteen inputs of 1 -> acc_data_out=21, acc_valid_out one cycle after the 16th input, filter_index 0 then 1.
- ReLU: bias[3]=-100, inputs summing to 40, RELU_ENABLE=1 -> output 0; with RELU_ENABLE=0 -> 0xFFFFFFC4.
- Gapped and back-to-back input: valid every other cycle for filter 0, then 32 consecutive valids -> identical sums, two pulses with no bubble.
- Wrap and done: run 120 filters -> layer_done only on the 120th pulse, then filter_index=0.
- Overflow: inputs 0x7FFFFFFF and 1 with IFM_DEPTH=2, bias 0, RELU off -> 0x80000000.
- Reset or clear after 7 of 16 inputs -> no pulse; the next 16 inputs give a clean sum for filter 0.
